// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: pixel format and the signed max used by pooling stages.
package cnn_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned FRAC_SZ    = 12;

    typedef logic signed [DATA_WIDTH-1:0] pixel_t;

    function automatic pixel_t smax(input pixel_t a, input pixel_t b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Simple dual-port line buffer for pooled pair maxima: synchronous write, registered read.
module pool_line_buffer #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so the buffer maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pooling stage; raster-order input, one output per window.
module maxpool_2x2_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_SZ    = 12,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         din_valid,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         frame_done
);

    import cnn_pkg::*;

    localparam int CW       = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW       = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB_DEPTH = (IMG_WIDTH >= 2) ? IMG_WIDTH / 2 : 1;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    if (IMG_WIDTH < 2 || (IMG_WIDTH % 2) != 0) begin : g_bad_width
        $error("maxpool_2x2_stream: IMG_WIDTH must be even and >= 2");
    end
    if (IMG_HEIGHT < 2 || (IMG_HEIGHT % 2) != 0) begin : g_bad_height
        $error("maxpool_2x2_stream: IMG_HEIGHT must be even and >= 2");
    end
    if (DATA_WIDTH != $bits(pixel_t) || FRAC_SZ >= DATA_WIDTH) begin : g_bad_format
        $error("maxpool_2x2_stream: pixel format does not match cnn_pkg");
    end

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    pixel_t                pair_reg;
    logic [AW-1:0]         lb_addr;
    logic                  lb_wr_en;
    logic                  lb_rd_en;
    pixel_t                lb_wr_data;
    logic [DATA_WIDTH-1:0] lb_rdata;
    logic                  accept;
    logic                  col_last;
    logic                  row_last;

    assign accept   = din_valid && !clear;
    assign col_last = (col == CW'(IMG_WIDTH - 1));
    assign row_last = (row == RW'(IMG_HEIGHT - 1));

    // Even row: store the horizontal pair max; odd row: prefetch it while the left pixel arrives.
    always_comb begin
        lb_addr    = AW'(col >> 1);
        lb_wr_en   = accept && col[0] && !row[0];
        lb_rd_en   = accept && !col[0] && row[0];
        lb_wr_data = smax(pair_reg, din);
    end

    pool_line_buffer #(
        .DEPTH      (LB_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (lb_addr),
        .wr_data (lb_wr_data),
        .rd_en   (lb_rd_en),
        .rd_addr (lb_addr),
        .rd_data (lb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            pair_reg   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
            if (din_valid) begin
                if (!col[0]) begin
                    pair_reg <= din;
                end else if (row[0]) begin
                    // Line-buffer read data was registered on the window's bottom-left pixel.
                    dout       <= smax(smax(pixel_t'(lb_rdata), pair_reg), din);
                    dout_valid <= 1'b1;
                    frame_done <= col_last && row_last;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Self-checking bench: 4x4 and 32x32 instances against a window-max reference model.
module tb_maxpool_2x2_stream;

    typedef struct {
        logic [15:0] v;
        int          cyc;
        logic        fd;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_s = 1'b0, clr_l = 1'b0;
    logic        dv_s = 1'b0, dv_l = 1'b0;
    logic [15:0] din_s = '0, din_l = '0;
    logic [15:0] dout_s, dout_l;
    logic        ov_s, ov_l, fd_s, fd_l;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fd_cnt_s = 0;
    int fd_cnt_l = 0;
    ev_t oq_s[$];
    ev_t oq_l[$];
    ev_t eq[$];
    logic [15:0] px[1024];
    int st[1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov_s) oq_s.push_back('{v: dout_s, cyc: cyc, fd: fd_s});
        if (ov_l) oq_l.push_back('{v: dout_l, cyc: cyc, fd: fd_l});
        if (fd_s) fd_cnt_s++;
        if (fd_l) fd_cnt_l++;
    end

    maxpool_2x2_stream #(
        .DATA_WIDTH (16),
        .FRAC_SZ    (12),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clr_s),
        .din        (din_s),
        .din_valid  (dv_s),
        .dout       (dout_s),
        .dout_valid (ov_s),
        .frame_done (fd_s)
    );

    maxpool_2x2_stream #(
        .DATA_WIDTH (16),
        .FRAC_SZ    (12),
        .IMG_WIDTH  (32),
        .IMG_HEIGHT (32)
    ) dut_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clr_l),
        .din        (din_l),
        .din_valid  (dv_l),
        .dout       (dout_l),
        .dout_valid (ov_l),
        .frame_done (fd_l)
    );

    // Reference: every 2x2 window's signed max, due one cycle after its bottom-right pixel.
    function automatic void model(input int w, input int h, input int base);
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                int best = int'($signed(px[base + 2 * r * w + 2 * c]));
                for (int k = 1; k < 4; k++) begin
                    int v = int'($signed(px[base + (2 * r + k / 2) * w + 2 * c + k % 2]));
                    if (v > best) best = v;
                end
                eq.push_back('{v: 16'(best), cyc: st[base + (2 * r + 1) * w + 2 * c + 1] + 1,
                               fd: (r == h / 2 - 1 && c == w / 2 - 1)});
            end
        end
    endfunction

    task automatic send_s(input int base, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin @(negedge clk); dv_s = 1'b0; end
            @(negedge clk);
            din_s = px[base + i];
            dv_s  = 1'b1;
            st[base + i] = cyc;
        end
        @(negedge clk);
        dv_s = 1'b0;
    endtask

    task automatic send_l(input int base, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin @(negedge clk); dv_l = 1'b0; end
            @(negedge clk);
            din_l = px[base + i];
            dv_l  = 1'b1;
            st[base + i] = cyc;
        end
        @(negedge clk);
        dv_l = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (dout_s !== 16'h0) begin failures++; $display("FAIL reset_dout_s got=%h want=0000", dout_s); end
        if (ov_s !== 1'b0) begin failures++; $display("FAIL reset_valid_s got=%b want=0", ov_s); end
        if (fd_s !== 1'b0) begin failures++; $display("FAIL reset_done_s got=%b want=0", fd_s); end
        if (dout_l !== 16'h0) begin failures++; $display("FAIL reset_dout_l got=%h want=0000", dout_l); end
        if (ov_l !== 1'b0) begin failures++; $display("FAIL reset_valid_l got=%b want=0", ov_l); end
        if (fd_l !== 1'b0) begin failures++; $display("FAIL reset_done_l got=%b want=0", fd_l); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic(input int max_gap);
        int o = oq_s.size();
        int f0 = fd_cnt_s;
        logic [15:0] want[4] = '{16'd6, 16'd8, 16'd14, 16'd16};
        eq.delete();
        for (int i = 0; i < 16; i++) px[i] = 16'(i + 1);
        send_s(0, 16, max_gap);
        model(4, 4, 0);
        repeat (3) @(negedge clk);
        checks += 2;
        if (oq_s.size() - o !== 4) begin failures++; $display("FAIL basic_count gap=%0d got=%0d want=4", max_gap, oq_s.size() - o); end
        if (fd_cnt_s - f0 !== 1) begin failures++; $display("FAIL basic_done_count gap=%0d got=%0d want=1", max_gap, fd_cnt_s - f0); end
        for (int i = 0; i < 4 && o + i < oq_s.size(); i++) begin
            checks += 2;
            if (oq_s[o + i].v !== want[i]) begin
                failures++; $display("FAIL basic_value%0d gap=%0d got=%0d want=%0d", i, max_gap, oq_s[o + i].v, want[i]);
            end
            if (oq_s[o + i].cyc !== eq[i].cyc || oq_s[o + i].fd !== eq[i].fd) begin
                failures++; $display("FAIL basic_timing%0d gap=%0d got=cyc%0d fd%b want=cyc%0d fd%b", i, max_gap,
                                     oq_s[o + i].cyc, oq_s[o + i].fd, eq[i].cyc, eq[i].fd);
            end
        end
    endtask

    task automatic test_signed();
        int o = oq_s.size();
        eq.delete();
        for (int i = 0; i < 16; i++) px[i] = 16'($urandom);
        px[0] = 16'h8000; px[1] = 16'hFFFF; px[4] = 16'h7000; px[5] = 16'h7000;
        px[2] = 16'hFFF0; px[3] = 16'hFFF0; px[6] = 16'hFFF0; px[7] = 16'hFFF0;
        send_s(0, 16, 1);
        model(4, 4, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (oq_s.size() - o !== 4) begin failures++; $display("FAIL signed_count got=%0d want=4", oq_s.size() - o); end
        if (oq_s.size() - o >= 2) begin
            checks += 2;
            if (oq_s[o].v !== 16'h7000) begin failures++; $display("FAIL signed_sat got=%h want=7000", oq_s[o].v); end
            if (oq_s[o + 1].v !== 16'hFFF0) begin failures++; $display("FAIL signed_neg got=%h want=fff0", oq_s[o + 1].v); end
        end
        for (int i = 0; i < eq.size() && o + i < oq_s.size(); i++) begin
            checks++;
            if (oq_s[o + i].v !== eq[i].v || oq_s[o + i].cyc !== eq[i].cyc || oq_s[o + i].fd !== eq[i].fd) begin
                failures++; $display("FAIL signed_out%0d got=%h@%0d fd%b want=%h@%0d fd%b", i, oq_s[o + i].v,
                                     oq_s[o + i].cyc, oq_s[o + i].fd, eq[i].v, eq[i].cyc, eq[i].fd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int o = oq_s.size();
        int f0 = fd_cnt_s;
        eq.delete();
        for (int i = 0; i < 16; i++) begin
            px[i]      = 16'($urandom_range(2000, 0)) - 16'd1000;
            px[i + 16] = px[i] + 16'd100;
        end
        send_s(0, 32, 0);
        model(4, 4, 0);
        model(4, 4, 16);
        repeat (3) @(negedge clk);
        checks += 2;
        if (oq_s.size() - o !== 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", oq_s.size() - o); end
        if (fd_cnt_s - f0 !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d want=2", fd_cnt_s - f0); end
        for (int i = 0; i < eq.size() && o + i < oq_s.size(); i++) begin
            checks++;
            if (oq_s[o + i].v !== eq[i].v || oq_s[o + i].cyc !== eq[i].cyc || oq_s[o + i].fd !== eq[i].fd) begin
                failures++; $display("FAIL b2b_out%0d got=%h@%0d fd%b want=%h@%0d fd%b", i, oq_s[o + i].v,
                                     oq_s[o + i].cyc, oq_s[o + i].fd, eq[i].v, eq[i].cyc, eq[i].fd);
            end
        end
    endtask

    // mode 0: rst_n abort, 1: clear abort, 2: clear coincident with a dropped pixel
    task automatic test_abort(input int mode);
        int o;
        for (int i = 0; i < 32; i++) px[i] = 16'($urandom);
        o = oq_s.size();
        send_s(0, (mode == 2) ? 5 : 9, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (oq_s.size() - o !== ((mode == 2) ? 0 : 2)) begin
            failures++; $display("FAIL abort%0d_partial got=%0d want=%0d", mode, oq_s.size() - o, (mode == 2) ? 0 : 2);
        end
        o = oq_s.size();
        if (mode == 0) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            clr_s = 1'b1;
            if (mode == 2) begin din_s = 16'h7FFF; dv_s = 1'b1; end
            @(negedge clk);
            clr_s = 1'b0;
            dv_s  = 1'b0;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (oq_s.size() - o !== 0) begin failures++; $display("FAIL abort%0d_stale got=%0d want=0", mode, oq_s.size() - o); end
        eq.delete();
        o = oq_s.size();
        send_s(16, 16, 2);
        model(4, 4, 16);
        repeat (3) @(negedge clk);
        checks++;
        if (oq_s.size() - o !== 4) begin failures++; $display("FAIL abort%0d_count got=%0d want=4", mode, oq_s.size() - o); end
        for (int i = 0; i < eq.size() && o + i < oq_s.size(); i++) begin
            checks++;
            if (oq_s[o + i].v !== eq[i].v || oq_s[o + i].cyc !== eq[i].cyc || oq_s[o + i].fd !== eq[i].fd) begin
                failures++; $display("FAIL abort%0d_out%0d got=%h@%0d fd%b want=%h@%0d fd%b", mode, i, oq_s[o + i].v,
                                     oq_s[o + i].cyc, oq_s[o + i].fd, eq[i].v, eq[i].cyc, eq[i].fd);
            end
        end
    endtask

    task automatic test_random_large();
        int o = oq_l.size();
        int f0 = fd_cnt_l;
        eq.delete();
        for (int i = 0; i < 1024; i++) px[i] = 16'($urandom);
        send_l(0, 1024, 1);
        model(32, 32, 0);
        repeat (3) @(negedge clk);
        checks += 2;
        if (oq_l.size() - o !== 256) begin failures++; $display("FAIL large_count got=%0d want=256", oq_l.size() - o); end
        if (fd_cnt_l - f0 !== 1) begin failures++; $display("FAIL large_done_count got=%0d want=1", fd_cnt_l - f0); end
        for (int i = 0; i < eq.size() && o + i < oq_l.size(); i++) begin
            checks++;
            if (oq_l[o + i].v !== eq[i].v || oq_l[o + i].cyc !== eq[i].cyc || oq_l[o + i].fd !== eq[i].fd) begin
                failures++; $display("FAIL large_out%0d got=%h@%0d fd%b want=%h@%0d fd%b", i, oq_l[o + i].v,
                                     oq_l[o + i].cyc, oq_l[o + i].fd, eq[i].v, eq[i].cyc, eq[i].fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_basic(3);
        test_signed();
        test_back_to_back();
        test_abort(0);
        test_abort(1);
        test_abort(2);
        test_random_large();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
